// File: rtl/c1541_sd_pkg.sv
// Shared types and helpers for the c1541 SD-channel arbiter.
package c1541_sd_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, RELEASE} arb_state_t;

    typedef enum logic {OP_RD, OP_WR} op_t;

    localparam int unsigned SECTOR_BYTES = 512;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/c1541_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module c1541_rr_pick
    import c1541_sd_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            cand = sum[IW-1:0];
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// Round-robin arbiter sharing one host SD block channel among NUM_DRIVES c1541 track units.
module c1541_sd_arbiter
    import c1541_sd_pkg::*;
#(
    parameter int unsigned NUM_DRIVES  = 2,
    parameter int unsigned ACK_TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_DRIVES-1:0]   drv_rd,
    input  logic [NUM_DRIVES-1:0]   drv_wr,
    input  logic [32*NUM_DRIVES-1:0] drv_lba,
    input  logic [8*NUM_DRIVES-1:0] drv_buff_din,
    output logic [NUM_DRIVES-1:0]   drv_ack,
    output logic [NUM_DRIVES-1:0]   drv_buff_wr,
    output logic [NUM_DRIVES-1:0]   drv_err,
    output logic [31:0]             sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    input  logic                    sd_buff_wr,
    output logic [7:0]              sd_buff_din,
    output logic                    busy
);

    localparam int unsigned IW           = idx_width(NUM_DRIVES);
    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    op_t             op_q, op_d;
    logic [31:0]     lba_q, lba_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [NUM_DRIVES-1:0] req;
    logic [NUM_DRIVES-1:0] pick_grant;
    logic [IW-1:0]         pick_idx;
    logic                  pick_valid;
    logic                  timeout;

    assign req     = drv_rd | drv_wr;
    assign timeout = (cnt_q == TIMEOUT_LAST);

    c1541_rr_pick #(
        .N  (NUM_DRIVES),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            op_q    <= OP_RD;
            lba_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        lba_d   = lba_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    // A pending write is serviced ahead of a reload on the same drive.
                    op_d    = (|(drv_wr & pick_grant)) ? OP_WR : OP_RD;
                    lba_d   = drv_lba[32*pick_idx +: 32];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    state_d = XFER;
                end else if (timeout) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                ptr_d   = (idx_q == IW'(NUM_DRIVES - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sd_rd       = (state_q == ISSUE) && (op_q == OP_RD);
        sd_wr       = (state_q == ISSUE) && (op_q == OP_WR);
        drv_ack     = '0;
        drv_buff_wr = '0;
        drv_err     = '0;
        sd_buff_din = 8'h00;
        if (state_q == XFER) begin
            drv_ack[idx_q]     = sd_ack;
            drv_buff_wr[idx_q] = sd_buff_wr;
        end
        if ((state_q == ISSUE) && !sd_ack && timeout) begin
            drv_err[idx_q] = 1'b1;
        end
        if (state_q != IDLE) begin
            sd_buff_din = drv_buff_din[8*idx_q +: 8];
        end
    end

    assign sd_lba = lba_q;
    assign busy   = (state_q != IDLE);

endmodule
